// File: rtl/io_tx_buffer.sv
// Byte FIFO between CPU I/O writes and a UART transmitter, with a stop
// sequence that queues a 0x00 terminator and halts once it has been sent.
module io_tx_buffer #(
  parameter int DEPTH_WIDTH = 3,
  parameter int FULL_MARGIN = 2
) (
  input  logic                   clockIn,
  input  logic                   resetIn,
  input  logic                   readyIn,
  input  logic                   ramSelect,
  input  logic [31:0]            ramAddr,
  input  logic [7:0]             ramOut,
  input  logic                   txReady,
  output logic                   txValid,
  output logic [7:0]             txData,
  output logic                   ioBufferFull,
  output logic [DEPTH_WIDTH:0]   count,
  output logic                   overflow,
  output logic                   programStop,
  output logic [1:0]             o_dbg_state
);

  localparam int DEPTH = 1 << DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH:0]   CNT_FULL = {1'b1, {DEPTH_WIDTH{1'b0}}};
  localparam logic [DEPTH_WIDTH:0]   CNT_ONE  = {{DEPTH_WIDTH{1'b0}}, 1'b1};
  localparam logic [DEPTH_WIDTH:0]   MARGIN   = FULL_MARGIN[DEPTH_WIDTH:0];
  localparam logic [DEPTH_WIDTH-1:0] PTR_ONE  = {{(DEPTH_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_RUN = 2'd0, S_DRAIN = 2'd1, S_HALTED = 2'd2} state_t;

  state_t                 r_state, w_state_next;
  logic [7:0]             r_mem [DEPTH];
  logic [DEPTH_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
  logic [DEPTH_WIDTH:0]   r_count;
  logic                   r_overflow, r_term_pending;

  logic       w_io_wr, w_data_wr, w_stop_wr, w_pop, w_space;
  logic       w_push, w_term_next, w_ovf_set;
  logic [7:0] w_push_byte;
  logic       w_unused_addr;

  assign w_unused_addr = &{1'b0, ramAddr[31:18], ramAddr[15:3]};

  assign w_io_wr   = readyIn & ramSelect & (ramAddr[17:16] == 2'b11);
  assign w_data_wr = w_io_wr & (ramAddr[2:0] == 3'd0) & (ramOut != 8'h00);
  assign w_stop_wr = w_io_wr & (ramAddr[2:0] == 3'd4);
  assign w_pop     = readyIn & txValid & txReady;
  // A pop in the same cycle frees the slot the push needs.
  assign w_space   = (r_count != CNT_FULL) | w_pop;

  always_comb begin
    w_state_next = r_state;
    w_push       = 1'b0;
    w_push_byte  = ramOut;
    w_term_next  = r_term_pending;
    w_ovf_set    = 1'b0;
    case (r_state)
      S_RUN: begin
        if (w_data_wr) begin
          if (w_space) w_push    = 1'b1;
          else         w_ovf_set = 1'b1;
        end
        if (w_stop_wr) begin
          w_state_next = S_DRAIN;
          w_term_next  = 1'b1;
        end
      end
      S_DRAIN: begin
        if (readyIn && r_term_pending && w_space) begin
          w_push      = 1'b1;
          w_push_byte = 8'h00;
          w_term_next = 1'b0;
        end
        // Terminator is always last, so the final pop after it is queued is it.
        if (w_pop && !r_term_pending && (r_count == CNT_ONE))
          w_state_next = S_HALTED;
      end
      S_HALTED: w_state_next = S_HALTED;
      default:  w_state_next = S_RUN;
    endcase
  end

  always_ff @(posedge clockIn or posedge resetIn) begin
    if (resetIn) begin
      r_state        <= S_RUN;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_overflow     <= 1'b0;
      r_term_pending <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_term_pending <= w_term_next;
      if (w_ovf_set) r_overflow <= 1'b1;
      if (w_push)    r_wr_ptr   <= r_wr_ptr + PTR_ONE;
      if (w_pop)     r_rd_ptr   <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clockIn) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_byte;
  end

  assign txValid      = (r_count != '0);
  assign txData       = r_mem[r_rd_ptr];
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign ioBufferFull = ((CNT_FULL - r_count) <= MARGIN);
  assign programStop  = (r_state == S_HALTED);
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_io_tx_buffer.sv
// Bench for io_tx_buffer: directed scenarios plus random traffic, checked
// every cycle against a queue-based model of the buffer and stop sequence.
module tb_io_tx_buffer;

  localparam int DEPTH  = 8;
  localparam int MARGIN = 2;

  logic        clockIn = 1'b0;
  logic        resetIn, readyIn, ramSelect, txReady;
  logic [31:0] ramAddr;
  logic [7:0]  ramOut;
  logic        txValid, ioBufferFull, overflow, programStop;
  logic [7:0]  txData;
  logic [3:0]  count;
  logic [1:0]  o_dbg_state;

  io_tx_buffer #(.DEPTH_WIDTH(3), .FULL_MARGIN(MARGIN)) dut (
    .clockIn(clockIn), .resetIn(resetIn), .readyIn(readyIn),
    .ramSelect(ramSelect), .ramAddr(ramAddr), .ramOut(ramOut),
    .txReady(txReady), .txValid(txValid), .txData(txData),
    .ioBufferFull(ioBufferFull), .count(count), .overflow(overflow),
    .programStop(programStop), .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  always #5 clockIn = ~clockIn;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: queue of bytes waiting for the UART
  logic [7:0] exp_q[$];
  int         m_mode;   // 0 running, 1 draining, 2 halted
  bit         m_term;
  bit         m_ovf;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_mode = 0;
    m_term = 1'b0;
    m_ovf  = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    int sz;
    sz = exp_q.size();
    check_val({tag, ".txValid"}, txValid, (sz != 0));
    check_val({tag, ".count"}, count, sz);
    check_val({tag, ".full"}, ioBufferFull, ((DEPTH - sz) <= MARGIN));
    check_val({tag, ".overflow"}, overflow, m_ovf);
    check_val({tag, ".programStop"}, programStop, (m_mode == 2));
    check_val({tag, ".state"}, o_dbg_state, m_mode);
    if (sz != 0) check_val({tag, ".txData"}, txData, exp_q[0]);
  endtask

  task automatic model_step(input bit rdy, input bit sel, input logic [31:0] addr,
                            input logic [7:0] d, input bit txr);
    bit         io, data_wr, stop_wr, pop, space;
    logic [7:0] popped;
    io      = rdy && sel && (addr[17:16] == 2'b11);
    data_wr = io && (addr[2:0] == 3'd0) && (d != 8'h00);
    stop_wr = io && (addr[2:0] == 3'd4);
    pop     = rdy && (exp_q.size() > 0) && txr;
    space   = (exp_q.size() < DEPTH) || pop;
    if (!rdy) return;
    popped = 8'hff;
    if (pop) popped = exp_q.pop_front();
    if (m_mode == 0) begin
      if (data_wr) begin
        if (space) exp_q.push_back(d);
        else       m_ovf = 1'b1;
      end
      if (stop_wr) begin
        m_mode = 1;
        m_term = 1'b1;
      end
    end else if (m_mode == 1) begin
      if (pop && popped == 8'h00) m_mode = 2;
      if (m_term && space) begin
        exp_q.push_back(8'h00);
        m_term = 1'b0;
      end
    end
  endtask

  // driver: apply inputs, check the pre-edge outputs, advance model and clock
  task automatic step(input bit rdy, input bit sel, input logic [31:0] addr,
                      input logic [7:0] d, input bit txr, input string tag);
    readyIn   = rdy;
    ramSelect = sel;
    ramAddr   = addr;
    ramOut    = d;
    txReady   = txr;
    #3;
    check_outputs(tag);
    model_step(rdy, sel, addr, d, txr);
    @(posedge clockIn);
    #1;
  endtask

  task automatic pulse_reset(input string tag);
    resetIn = 1'b1;
    #1;
    model_reset();
    check_outputs(tag);
    resetIn = 1'b0;
    #1;
  endtask

  task automatic wr(input logic [7:0] d, input bit txr, input string tag);
    step(1'b1, 1'b1, 32'h0003_0000, d, txr, tag);
  endtask

  task automatic idle(input bit txr, input string tag);
    step(1'b1, 1'b0, 32'h0, 8'h00, txr, tag);
  endtask

  initial begin
    resetIn = 1'b1; readyIn = 1'b0; ramSelect = 1'b0;
    ramAddr = '0; ramOut = '0; txReady = 1'b0;
    model_reset();
    @(posedge clockIn);
    #1;
    check_outputs("reset");
    resetIn = 1'b0;
    #1;

    // single write shows up one cycle later
    wr(8'h41, 1'b0, "w41");
    idle(1'b0, "after_w41");
    idle(1'b1, "pop41");
    idle(1'b0, "empty1");

    // fill, overflow drop, ordered drain
    for (int i = 1; i <= 8; i++) wr(i[7:0], 1'b0, "fill");
    wr(8'h09, 1'b0, "drop09");
    idle(1'b0, "full_held");
    for (int i = 0; i < 9; i++) idle(1'b1, "drain");

    // full with simultaneous push and pop
    pulse_reset("reset2");
    for (int i = 1; i <= 8; i++) wr(i[7:0], 1'b0, "fill2");
    wr(8'h55, 1'b1, "push_pop_full");
    for (int i = 0; i < 9; i++) idle(1'b1, "drain2");

    // ignored writes
    wr(8'h00, 1'b0, "zero_wr");
    step(1'b1, 1'b1, 32'h0000_0010, 8'h30, 1'b0, "non_io");
    step(1'b1, 1'b0, 32'h0003_0000, 8'h31, 1'b0, "read");
    idle(1'b0, "ignored");

    // pause holds everything
    wr(8'h21, 1'b0, "p1");
    wr(8'h22, 1'b0, "p2");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h0003_0004, 8'h23, 1'b1, "paused");
    for (int i = 0; i < 3; i++) idle(1'b1, "unpause");

    // stop sequence
    wr(8'h61, 1'b0, "w61");
    step(1'b1, 1'b1, 32'h0003_0004, 8'h00, 1'b0, "stop");
    wr(8'h62, 1'b0, "w62_ignored");
    for (int i = 0; i < 4; i++) idle(1'b1, "stop_drain");
    wr(8'h70, 1'b0, "halted_wr");
    idle(1'b0, "halted");

    // reset while draining, then immediate write
    pulse_reset("reset3");
    wr(8'h11, 1'b0, "d1");
    wr(8'h12, 1'b0, "d2");
    step(1'b1, 1'b1, 32'h0003_0004, 8'h00, 1'b0, "stop2");
    idle(1'b0, "in_drain");
    pulse_reset("reset_drain");
    wr(8'h33, 1'b0, "post_reset_wr");
    idle(1'b0, "post_reset");

    // random traffic
    for (int n = 0; n < 600; n++) begin
      logic [31:0] addr;
      logic [7:0]  d;
      int          pick;
      if (n % 60 == 0) pulse_reset("rnd_reset");
      pick = $urandom_range(0, 39);
      if (pick < 24)      addr = 32'h0003_0000;
      else if (pick < 25) addr = 32'h0003_0004;
      else if (pick < 30) addr = 32'h0003_0008;
      else if (pick < 35) addr = 32'h0000_0010;
      else                addr = 32'h0002_0000;
      d = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      step($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1, addr, d,
           $urandom_range(0, 2) == 0, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
